// File: rtl/decoder_pkg.sv
// Shared definitions for the pipelined one-hot decoder: skid buffer state
// encoding and default address/output widths.
package decoder_pkg;

  localparam int DEF_IN_W  = 3;
  localparam int DEF_OUT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/decoder_n_pipe_if.sv
// Request/response handshake bundle for decoder_n_pipe. out_err exists only
// when DECODER_RANGE_ERR_EN is defined.
interface decoder_n_pipe_if
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_addr;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_y;
`ifdef DECODER_RANGE_ERR_EN
  logic             out_err;

  modport slave (
    input  in_valid, in_addr, in_en, out_ready,
    output in_ready, out_valid, out_y, out_err
  );

  modport master (
    output in_valid, in_addr, in_en, out_ready,
    input  in_ready, out_valid, out_y, out_err
  );
`else
  modport slave (
    input  in_valid, in_addr, in_en, out_ready,
    output in_ready, out_valid, out_y
  );

  modport master (
    output in_valid, in_addr, in_en, out_ready,
    input  in_ready, out_valid, out_y
  );
`endif

endinterface

// File: rtl/decoder_skid_buf.sv
// Two-entry skid buffer (EMPTY/ONE/FULL) with a registered in_ready so the
// downstream out_ready never reaches in_ready combinationally.
module decoder_skid_buf
  import decoder_pkg::*;
#(
  parameter int W = DEF_OUT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state, state_nxt;
  logic [W-1:0] skid_q;
  logic         accept, drain;
  logic         load_head, load_skid, head_from_skid;

  assign out_valid = (state != EMPTY);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    accept         = in_valid && in_ready;
    drain          = out_valid && out_ready;
    state_nxt      = state;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (accept && drain) begin
          load_head = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can move the state.
        if (drain) begin
          state_nxt      = ONE;
          load_head      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      if (load_head) out_data <= head_from_skid ? skid_q : in_data;
    end
  end

  // NOTE: the skid entry is storage, not control: it is never visible before
  // being written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= in_data;
  end

endmodule

// File: rtl/decoder_n_pipe.sv
// Pipelined N-to-one-hot decoder: combinational decode at the input, decoded
// word buffered in a skid buffer. Optional out_err via DECODER_RANGE_ERR_EN.
module decoder_n_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input logic              clk,
  input logic              rst,
  decoder_n_pipe_if.slave  bus
);

`ifdef DECODER_RANGE_ERR_EN
  localparam int DW = OUT_W + 1;
`else
  localparam int DW = OUT_W;
`endif

  logic [IN_W-1:0]  addr;
  logic [OUT_W-1:0] dec_y;
  logic [DW-1:0]    din, dout;

  assign addr = bus.in_addr;

  // Addresses at or beyond OUT_W match no bit, so they decode to zero.
  always_comb begin
    dec_y = '0;
    for (int i = 0; i < OUT_W; i++) begin
      dec_y[i] = bus.in_en && (int'(addr) == i);
    end
  end

`ifdef DECODER_RANGE_ERR_EN
  logic dec_err;
  assign dec_err     = (int'(addr) >= OUT_W);
  assign din         = {dec_err, dec_y};
  assign bus.out_y   = dout[OUT_W-1:0];
  assign bus.out_err = dout[OUT_W];
`else
  assign din       = dec_y;
  assign bus.out_y = dout;
`endif

  decoder_skid_buf #(
    .W (DW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (din),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (dout)
  );

endmodule

// File: tb/tb_decoder_n_pipe.sv
// Self-checking bench for decoder_n_pipe: vector table, handshake corner
// sequences, random valid/ready traffic against a scoreboard queue.
module tb_decoder_n_pipe;

  typedef struct {
    logic [2:0] addr;
    logic       en;
    logic [7:0] y;
  } vec_t;

  typedef struct packed {
    logic [7:0] y;
    logic       err;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decoder_n_pipe_if #(.IN_W(3), .OUT_W(8)) bus ();
  decoder_n_pipe_if #(.IN_W(3), .OUT_W(6)) bus6 ();

  decoder_n_pipe #(.IN_W(3), .OUT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  decoder_n_pipe #(.IN_W(3), .OUT_W(6)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  bit         mon_en = 1'b0;
  logic [7:0] drv_y  = '0;
  logic       drv_err = 1'b0;
  sb_t        q[$];
  bit         prev_hold = 1'b0;
  logic [7:0] prev_y = '0;
  logic       prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_y(input logic [2:0] a, input logic en);
    logic [7:0] one = 8'h01;
    model_y = en ? (one << a) : 8'h00;
  endfunction

  // Scoreboard: handshakes are judged at negedge, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        q.delete();
        prev_hold = 1'b0;
      end else begin
        check("out_valid_vs_model", bus.out_valid, q.size() != 0);
        check("in_ready_vs_model", bus.in_ready, q.size() < 2);
        if (prev_hold) begin
          check("hold_stable_y", bus.out_y, prev_y);
`ifdef DECODER_RANGE_ERR_EN
          check("hold_stable_err", bus.out_err, prev_err);
`endif
        end
        if (bus.out_valid) check("onehot0", $onehot0(bus.out_y), 1);
        if (bus.out_valid && bus.out_ready && q.size() != 0) begin
          sb_t e;
          e = q.pop_front();
          check("payload_y", bus.out_y, e.y);
`ifdef DECODER_RANGE_ERR_EN
          check("payload_err", bus.out_err, e.err);
`endif
        end
        if (bus.in_valid && bus.in_ready) q.push_back('{drv_y, drv_err});
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_y    = bus.out_y;
`ifdef DECODER_RANGE_ERR_EN
        prev_err  = bus.out_err;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] a, input logic en, input logic [7:0] ey);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_en    = en;
    drv_y        = ey;
    drv_err      = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
    end
    check("accept_within_bound", ok, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send6(input logic [2:0] a, input logic en, input logic [5:0] ey, input logic ee);
    bus6.in_valid = 1'b1;
    bus6.in_addr  = a;
    bus6.in_en    = en;
    @(negedge clk);
    check("w6_in_ready", bus6.in_ready, 1);
    tick();
    bus6.in_valid = 1'b0;
    @(negedge clk);
    check("w6_out_valid", bus6.out_valid, 1);
    check("w6_out_y", bus6.out_y, ey);
`ifdef DECODER_RANGE_ERR_EN
    check("w6_out_err", bus6.out_err, ee);
`else
    if (ee) check("w6_oor_zero", bus6.out_y, 0);
`endif
    tick();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   t0;
    vecs[0]  = '{3'd0, 1'b1, 8'h01};
    vecs[1]  = '{3'd1, 1'b1, 8'h02};
    vecs[2]  = '{3'd2, 1'b1, 8'h04};
    vecs[3]  = '{3'd3, 1'b1, 8'h08};
    vecs[4]  = '{3'd4, 1'b1, 8'h10};
    vecs[5]  = '{3'd5, 1'b1, 8'h20};
    vecs[6]  = '{3'd6, 1'b1, 8'h40};
    vecs[7]  = '{3'd7, 1'b1, 8'h80};
    vecs[8]  = '{3'd5, 1'b0, 8'h00};
    vecs[9]  = '{3'd0, 1'b0, 8'h00};
    vecs[10] = '{3'd7, 1'b0, 8'h00};
    vecs[11] = '{3'd3, 1'b1, 8'h08};

    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_en     = 1'b0;
    bus.out_ready = 1'b1;
    bus6.in_valid  = 1'b0;
    bus6.in_addr   = '0;
    bus6.in_en     = 1'b0;
    bus6.out_ready = 1'b1;

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_in_ready", bus.in_ready, 1);
`ifdef DECODER_RANGE_ERR_EN
    check("rst_out_err", bus.out_err, 0);
`endif
    tick();
    mon_en = 1'b1;

    // Back-to-back vector table with out_ready held high: one word per cycle.
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(vecs[i].addr, vecs[i].en, vecs[i].y);
    check("throughput_8_cycles", cyc - t0, 8);
    for (int i = 8; i < 12; i++) send(vecs[i].addr, vecs[i].en, vecs[i].y);
    repeat (3) tick();

    // Stalled downstream: two accepted, third blocked, then released in order.
    bus.out_ready = 1'b0;
    send(3'd1, 1'b1, 8'h02);
    send(3'd2, 1'b1, 8'h04);
    bus.in_valid = 1'b1;
    bus.in_addr  = 3'd3;
    bus.in_en    = 1'b1;
    drv_y        = 8'h08;
    @(negedge clk);
    check("full_in_ready_low", bus.in_ready, 0);
    check("full_head_word", bus.out_y, 8'h02);
    tick();
    @(negedge clk);
    check("full_still_blocked", bus.in_ready, 0);
    tick();
    bus.out_ready = 1'b1;
    send(3'd3, 1'b1, 8'h08);
    repeat (4) tick();
    check("stall_drained", q.size(), 0);

    // Reset while FULL, with handshake inputs active during the reset cycle.
    bus.out_ready = 1'b0;
    send(3'd6, 1'b1, 8'h40);
    send(3'd1, 1'b1, 8'h02);
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_addr   = 3'd2;
    bus.in_en     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_y", bus.out_y, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    tick();
    send(3'd4, 1'b1, 8'h10);
    @(negedge clk);
    check("post_rst_word", bus.out_y, 8'h10);
    tick();
    repeat (2) tick();

    // Narrow instance: in-range, boundary and out-of-range addresses.
    send6(3'd5, 1'b1, 6'h20, 1'b0);
    send6(3'd6, 1'b1, 6'h00, 1'b1);
    send6(3'd7, 1'b1, 6'h00, 1'b1);
    send6(3'd7, 1'b0, 6'h00, 1'b1);
    send6(3'd0, 1'b0, 6'h00, 1'b0);

    // Random valid/ready traffic.
    begin
      int         sent = 0;
      int         n    = 0;
      bit         pend = 1'b0;
      logic [2:0] a;
      logic       e;
      while (sent < 10000 && n < 40000) begin
        if (!pend && $urandom_range(0, 7) != 0) begin
          a = 3'($urandom_range(0, 7));
          e = ($urandom_range(0, 3) != 0);
          bus.in_addr = a;
          bus.in_en   = e;
          drv_y       = model_y(a, e);
          drv_err     = 1'b0;
          pend        = 1'b1;
        end
        bus.in_valid  = pend;
        bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (pend && bus.in_ready) begin
          pend = 1'b0;
          sent++;
        end
        tick();
        n++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("rand_words_sent", sent, 10000);
      for (int t = 0; t < 10 && q.size() != 0; t++) tick();
      check("rand_drained", q.size(), 0);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_n_pipe.md
DECODER_N_PIPE -- requirements
Module: decoder_n_pipe

Interface
REQ-001 Parameter IN_W, default 3: address width in bits, legal range 1..8.
REQ-002 Parameter OUT_W, default 8: one-hot output width, legal range 2..2**IN_W.
REQ-003 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port in_valid, input, 1: upstream presents a request.
REQ-006 Port in_ready, output, 1: block can accept a request this cycle.
REQ-007 Port in_addr, input, IN_W: index to decode.
REQ-008 Port in_en, input, 1: decode enable; 0 yields all-zero output word.
REQ-009 Port out_valid, output, 1: out_y holds a valid decoded word.
REQ-010 Port out_ready, input, 1: downstream accepts the word this cycle.
REQ-011 Port out_y, output, OUT_W: decoded one-hot or zero word.
REQ-012 Port out_err, output, 1: out-of-range flag; present only when DECODER_RANGE_ERR_EN is defined.

Function
REQ-013 Transfer occurs on a side when valid and ready are both high at a rising edge.
REQ-014 Decode: bit i of the word is 1 iff in_en=1 and in_addr==i; at most one bit is set.
REQ-015 in_addr >= OUT_W shall yield an all-zero word regardless of in_en.
REQ-016 Decode is performed combinationally at the input; only the decoded word (plus error bit) is stored.
REQ-017 Storage is a 2-entry skid buffer with states EMPTY, ONE, FULL.
REQ-018 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-019 ONE: accept without drain -> FULL; drain without accept -> EMPTY; accept and drain together -> ONE.
REQ-020 FULL: drain -> ONE; no drain -> FULL; no accept is possible.
REQ-021 in_ready shall be a registered signal equal to (state != FULL); no combinational path from out_ready to in_ready.
REQ-022 Latency: a word accepted in cycle N appears on out_y with out_valid=1 in cycle N+1.
REQ-023 Throughput: one word per cycle sustained while out_ready is held high.
REQ-024 Output order shall equal acceptance order; no word lost or duplicated.
REQ-025 out_y and out_err shall hold stable while out_valid=1 and out_ready=0.
REQ-026 out_valid shall be 1 iff state != EMPTY.

Reset
REQ-027 With rst=1 at a rising edge: state=EMPTY, out_valid=0, out_y=0, out_err=0, in_ready=1 on the following cycle.
REQ-028 Reset mid-operation discards all buffered words; in_valid and out_ready are ignored during the reset cycle.

Configuration
REQ-029 Macro DECODER_RANGE_ERR_EN defined: out_err exists and is 1 alongside each word whose in_addr >= OUT_W; it is buffered with the word.
REQ-030 Macro undefined: out_err port and its storage are absent; out-of-range words are still all-zero per REQ-015.

Structure
REQ-031 Shared package decoder_pkg holds the skid state encoding (EMPTY/ONE/FULL) and the IN_W/OUT_W default constants.
REQ-032 Skid buffer is a sub-module decoder_skid_buf, parametrised by data width (OUT_W, plus 1 when DECODER_RANGE_ERR_EN is defined).

Verification
REQ-033 Defaults, out_ready=1, in_en=1, addrs 0..7 back-to-back -> out_y 0x01,0x02,...,0x80 on consecutive cycles, one cycle after each accept.
REQ-034 in_en=0, addr=5 -> out_y=0x00, out_valid=1 one cycle later.
REQ-035 out_ready=0, three requests addrs 1,2,3 -> two accepted, in_ready=0 after the second; release out_ready -> 0x02,0x04,0x08 in order.
REQ-036 IN_W=3, OUT_W=6, addr=7, macro defined -> out_y=0x00, out_err=1; macro undefined -> out_y=0x00, no out_err port.
REQ-037 FULL state, rst=1 for one cycle -> out_valid=0, out_y=0, in_ready=1 next cycle; next accepted addr=4 -> out_y=0x10.
REQ-038 Random valid/ready toggling, 10k words -> scoreboard sees in-order, one-hot-or-zero words matching REQ-014/015; stability per REQ-025 holds.
